// File: rtl/apb_requester.sv
// APB3/APB4 initiator: one command at a time, runs SETUP/ACCESS against an APB slave.
// Optional ACCESS timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_requester #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PSELx,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W/8-1:0] pstrb_q, pstrb_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    // Ready is decoded from registered state only; gated low while reset is held.
    assign cmd_ready = (state_q == IDLE) && !rsp_valid_q && !PRESET;

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_addr[1:0] != 2'b00) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        paddr_d  = cmd_addr;
                        pwrite_d = cmd_write;
                        pwdata_d = cmd_wdata;
                        pstrb_d  = cmd_write ? cmd_strb : '0;
                        psel_d   = 1'b1;
                        state_d  = SETUP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = (pwrite_q || PSLVERR) ? '0 : PRDATA;
                    state_d     = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PSELx     = psel_q;
    assign PENABLE   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed scenarios plus randomized transactions
// checked against a transaction-level expectation model.
module tb_apb_requester;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [3:0]  PSTRB;

    int unsigned total = 0;
    int unsigned bad   = 0;

    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete transaction; expectations come from the command attributes alone.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int unsigned waits, input logic slverr,
                           input logic [31:0] prd, input int unsigned hold, input logic poke);
        logic        mis;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [3:0]  exp_strb;
        mis      = (addr[1:0] != 2'b00);
        exp_err  = mis | slverr;
        exp_rd   = (wr || exp_err) ? 32'h0 : prd;
        exp_strb = wr ? strb : 4'h0;

        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        @(negedge PCLK);
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_strb = 4'($urandom);

        if (!mis) begin
            total++;
            if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid}
                !== {1'b1, 1'b0, wr, addr, wdata, exp_strb, 1'b0}) begin
                bad++;
                $display("FAIL setup: got sel=%b en=%b wr=%b a=%h d=%h s=%h rv=%b want 1 0 %b %h %h %h 0",
                         PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, wr, addr, wdata, exp_strb);
            end
            @(negedge PCLK);
            for (int unsigned k = 0; k <= waits; k++) begin
                total++;
                if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid}
                    !== {1'b1, 1'b1, wr, addr, wdata, exp_strb, 1'b0}) begin
                    bad++;
                    $display("FAIL access[%0d]: got sel=%b en=%b a=%h s=%h rv=%b want 1 1 %h %h 0",
                             k, PSELx, PENABLE, PADDR, PSTRB, rsp_valid, addr, exp_strb);
                end
                PREADY  = (k == waits);
                PSLVERR = (k == waits) ? slverr : 1'($urandom);
                PRDATA  = (k == waits) ? prd : $urandom;
                @(negedge PCLK);
            end
            PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
        end

        total++;
        if ({PSELx, PENABLE, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b0, 1'b1, exp_err, exp_rd}) begin
            bad++;
            $display("FAIL response: got sel=%b en=%b rv=%b err=%b rd=%h want 0 0 1 %b %h",
                     PSELx, PENABLE, rsp_valid, rsp_err, rsp_rdata, exp_err, exp_rd);
        end

        for (int unsigned h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            if (poke) begin
                cmd_valid = 1'b1; cmd_addr = {$urandom} & 32'hFFFF_FFFC;
            end
            total++;
            if ({cmd_ready, PSELx, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b0, 1'b1, exp_err, exp_rd}) begin
                bad++;
                $display("FAIL hold[%0d]: got rdy=%b sel=%b rv=%b err=%b rd=%h want 0 0 1 %b %h",
                         h, cmd_ready, PSELx, rsp_valid, rsp_err, rsp_rdata, exp_err, exp_rd);
            end
            @(negedge PCLK);
        end

        rsp_ready = 1'b1;
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++; $display("FAIL ready_while_rsp: got %b want 0", cmd_ready);
        end
        @(negedge PCLK);
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        total++;
        if ({rsp_valid, PSELx, cmd_ready} !== 3'b001) begin
            bad++;
            $display("FAIL retire: got rv=%b sel=%b rdy=%b want 0 0 1", rsp_valid, PSELx, cmd_ready);
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #2;
        total++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PSELx, PENABLE, PWRITE, PWDATA, PSTRB} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b sel=%b en=%b a=%h want all 0",
                     cmd_ready, rsp_valid, PSELx, PENABLE, PADDR);
        end
        @(negedge PCLK); @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        total++;
        if ({cmd_ready, PSELx, rsp_valid} !== 3'b100) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b sel=%b rv=%b want 1 0 0", cmd_ready, PSELx, rsp_valid);
        end
    endtask

    task automatic test_write_zero_wait();
        run_txn(1'b1, 32'h8, 32'h1, 4'b0001, 0, 1'b0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_read_wait();
        run_txn(1'b0, 32'hC, 32'h5555_0000, 4'hF, 3, 1'b0, 32'h0000_000A, 1, 1'b0);
    endtask

    task automatic test_slverr_backpressure();
        run_txn(1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, 32'h1234_5678, 5, 1'b1);
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 32'h6, 32'h0, 4'h0, 0, 1'b0, 32'hFFFF_FFFF, 2, 1'b0);
    endtask

    task automatic test_async_reset();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        total++;
        if ({PSELx, PENABLE} !== 2'b11) begin
            bad++; $display("FAIL pre_reset_access: got sel=%b en=%b want 1 1", PSELx, PENABLE);
        end
        PRESET = 1'b1;
        #1;
        total++;
        if ({PSELx, PENABLE, rsp_valid} !== 3'b000) begin
            bad++;
            $display("FAIL async_reset: got sel=%b en=%b rv=%b want 0 0 0", PSELx, PENABLE, rsp_valid);
        end
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        total++;
        if ({PSELx, rsp_valid, cmd_ready} !== 3'b001) begin
            bad++;
            $display("FAIL after_reset: got sel=%b rv=%b rdy=%b want 0 0 1", PSELx, rsp_valid, cmd_ready);
        end
        run_txn(1'b0, 32'h14, 32'h0, 4'hF, 1, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
    endtask

    task automatic test_timeout();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; PREADY = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        for (int unsigned k = 0; k < 4; k++) begin
            total++;
            if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin
                bad++;
                $display("FAIL stuck_access[%0d]: got sel=%b en=%b rv=%b want 1 1 0", k, PSELx, PENABLE, rsp_valid);
            end
            @(negedge PCLK);
        end
`ifdef APB_TIMEOUT_EN
        total++;
        if ({PSELx, PENABLE, rsp_valid, rsp_err, rsp_rdata} !== {4'b0011, 32'h0}) begin
            bad++;
            $display("FAIL timeout_abort: got sel=%b en=%b rv=%b err=%b rd=%h want 0 0 1 1 0",
                     PSELx, PENABLE, rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            bad++; $display("FAIL timeout_retire: got rv=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
        end
`else
        for (int unsigned k = 0; k < 40; k++) begin
            total++;
            if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin
                bad++;
                $display("FAIL no_timeout[%0d]: got sel=%b en=%b rv=%b want 1 1 0", k, PSELx, PENABLE, rsp_valid);
            end
            @(negedge PCLK);
        end
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
`endif
    endtask

    task automatic test_random();
        for (int unsigned n = 0; n < 40; n++) begin
            logic        wr;
            logic [31:0] addr;
            wr   = 1'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
            run_txn(wr, addr, $urandom, 4'($urandom), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 32'h40, 32'hA5A5_A5A5, 4'b1010, 0, 1'b0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 32'h40, 32'h0, 4'hF, 0, 1'b0, 32'h0BAD_CAFE, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr_backpressure();
        test_misaligned();
        test_async_reset();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
